// File: rtl/stoplight_pkg.sv
// Shared stoplight definitions: pedestrian FSM encoding, default timing, counter widths.
package stoplight_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned COOLDOWN_DEFAULT = 8;
  localparam int unsigned REQ_CNT_W        = 8;
  localparam int unsigned DB_CNT_W         = 8;
  localparam int unsigned COOL_CNT_W       = 8;

  typedef enum logic [1:0] {
    PED_IDLE     = 2'd0,
    PED_PENDING  = 2'd1,
    PED_SERVING  = 2'd2,
    PED_COOLDOWN = 2'd3
  } ped_state_e;

endpackage

// File: rtl/ped_debounce.sv
// Two-flop synchronizer followed by a counter debouncer for the pedestrian button.
module ped_debounce #(
  parameter int unsigned DEBOUNCE = stoplight_pkg::DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic PedBtn,
  output logic BtnClean
);
  import stoplight_pkg::*;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE - 1);

  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                clean_q, clean_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreements between s2 and the clean level; flip on the last one.
  always_comb begin
    s1_d    = PedBtn;
    s2_d    = s1_q;
    clean_d = clean_q;
    cnt_d   = '0;
    if (s2_q != clean_q) begin
      if (cnt_q == DB_LAST) begin
        clean_d = ~clean_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  // Synchronizer, clean level and debounce counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BtnClean = clean_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian request holder: debounced press -> held Ped request until the road goes red,
// then a lockout before the next request is accepted.
module ped_request #(
  parameter int unsigned DEBOUNCE = stoplight_pkg::DEBOUNCE_DEFAULT,
  parameter int unsigned COOLDOWN = stoplight_pkg::COOLDOWN_DEFAULT
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                PedBtn,
  input  logic                                SigR,
  output logic                                Ped,
  output logic                                BtnClean,
  output logic [1:0]                          PedState,
  output logic [stoplight_pkg::REQ_CNT_W-1:0] ReqCount
);
  import stoplight_pkg::*;

  localparam logic [COOL_CNT_W-1:0] COOL_LOAD =
    (COOLDOWN == 0) ? '0 : COOL_CNT_W'(COOLDOWN - 1);

  logic                  btn_clean;
  logic                  prev_q, prev_d;
  logic                  press;
  ped_state_e            state_q, state_d;
  logic [COOL_CNT_W-1:0] cool_q, cool_d;
  logic [REQ_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  ped_q, ped_d;

  ped_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .CLK      (CLK),
    .RST      (RST),
    .PedBtn   (PedBtn),
    .BtnClean (btn_clean)
  );

  assign press = btn_clean & ~prev_q;

  // Next-state, cooldown counter and saturating request counter.
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    cnt_d   = cnt_q;
    prev_d  = btn_clean;
    case (state_q)
      PED_IDLE: begin
        if (press) begin
          state_d = PED_PENDING;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + REQ_CNT_W'(1);
          end
        end
      end
      PED_PENDING: begin
        if (SigR) begin
          state_d = PED_SERVING;
        end
      end
      PED_SERVING: begin
        if (!SigR) begin
          if (COOLDOWN == 0) begin
            state_d = PED_IDLE;
          end else begin
            state_d = PED_COOLDOWN;
            cool_d  = COOL_LOAD;
          end
        end
      end
      PED_COOLDOWN: begin
        if (cool_q == '0) begin
          state_d = PED_IDLE;
        end else begin
          cool_d = cool_q - COOL_CNT_W'(1);
        end
      end
      default: state_d = PED_IDLE;
    endcase
    ped_d = (state_d == PED_PENDING);
  end

  // State and counter registers; reset overrides every transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PED_IDLE;
      cool_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      ped_q   <= ped_d;
    end
  end

  assign Ped      = ped_q;
  assign BtnClean = btn_clean;
  assign PedState = state_q;
  assign ReqCount = cnt_q;

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: reference model compared every cycle plus pinned literal checks.
module tb_ped_request;

  localparam int DEB  = 4;
  localparam int COOL = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PedBtn;
  logic       SigR;
  logic       Ped;
  logic       BtnClean;
  logic [1:0] PedState;
  logic [7:0] ReqCount;

  int n_vec  = 0;
  int n_miss = 0;

  ped_request #(
    .DEBOUNCE (DEB),
    .COOLDOWN (COOL)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PedBtn   (PedBtn),
    .SigR     (SigR),
    .Ped      (Ped),
    .BtnClean (BtnClean),
    .PedState (PedState),
    .ReqCount (ReqCount)
  );

  always #5 CLK = ~CLK;

  // Reference model: button delayed by two samples; clean level flips once the delayed
  // button has disagreed with it for the last DEB samples; request phases from the rules.
  bit m_valid = 0;
  bit m_s1, m_s2, m_clean, m_prev;
  bit s2_hist[$];
  int m_state, m_cool, m_acc;

  always @(posedge CLK) begin : model
    bit press, flip;
    if (RST) begin
      m_valid = 1; m_s1 = 0; m_s2 = 0; m_clean = 0; m_prev = 0;
      s2_hist.delete();
      m_state = 0; m_cool = 0; m_acc = 0;
    end else begin
      press  = m_clean && !m_prev;
      m_prev = m_clean;
      s2_hist.push_back(m_s2);
      if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
      flip = (s2_hist.size() == DEB);
      foreach (s2_hist[i]) if (s2_hist[i] == m_clean) flip = 0;
      if (flip) m_clean = !m_clean;
      m_s2 = m_s1;
      m_s1 = PedBtn;
      case (m_state)
        0: if (press) begin m_state = 1; m_acc++; end
        1: if (SigR) m_state = 2;
        2: if (!SigR) begin
             if (COOL == 0) m_state = 0;
             else begin m_state = 3; m_cool = COOL; end
           end
        default: begin
          m_cool--;
          if (m_cool == 0) m_state = 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("model BtnClean", int'(BtnClean), int'(m_clean));
      check("model Ped",      int'(Ped),      int'(m_state == 1));
      check("model PedState", int'(PedState), m_state);
      check("model ReqCount", int'(ReqCount), (m_acc > 255) ? 255 : m_acc);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; PedBtn = 1'b0; SigR = 1'b0;
    wait_neg(2);
    check("reset Ped", int'(Ped), 0);
    check("reset PedState", int'(PedState), 0);
    check("reset ReqCount", int'(ReqCount), 0);

    // Clean step held from reset release: BtnClean at edge 6, Ped at edge 7.
    RST = 1'b0; PedBtn = 1'b1;
    wait_neg(5);
    check("lat BtnClean e5", int'(BtnClean), 0);
    wait_neg(1);
    check("lat BtnClean e6", int'(BtnClean), 1);
    check("lat Ped e6", int'(Ped), 0);
    wait_neg(1);
    check("lat Ped e7", int'(Ped), 1);
    check("lat PedState e7", int'(PedState), 1);
    check("lat ReqCount e7", int'(ReqCount), 1);

    // Serve, with a discarded press during SERVING.
    SigR = 1'b1;
    wait_neg(1);
    check("serve Ped", int'(Ped), 0);
    check("serve PedState", int'(PedState), 2);
    PedBtn = 1'b0;
    wait_neg(8);
    PedBtn = 1'b1;
    wait_neg(8);
    check("serving press BtnClean", int'(BtnClean), 1);
    check("serving press ReqCount", int'(ReqCount), 1);
    check("serving press PedState", int'(PedState), 2);
    PedBtn = 1'b0;
    wait_neg(8);

    // Cooldown for COOL edges, with a discarded press inside it.
    SigR = 1'b0; PedBtn = 1'b1;
    wait_neg(1);
    check("cool entry PedState", int'(PedState), 3);
    wait_neg(7);
    check("cool edge 8 PedState", int'(PedState), 3);
    check("cool press BtnClean", int'(BtnClean), 1);
    wait_neg(1);
    check("cool exit PedState", int'(PedState), 0);
    check("cool press ReqCount", int'(ReqCount), 1);
    check("cool exit Ped", int'(Ped), 0);

    // Fresh press in IDLE is accepted.
    PedBtn = 1'b0;
    wait_neg(8);
    PedBtn = 1'b1;
    wait_neg(7);
    check("second press ReqCount", int'(ReqCount), 2);
    check("second press Ped", int'(Ped), 1);

    // One-cycle reset while PENDING.
    RST = 1'b1;
    wait_neg(1);
    check("midreset Ped", int'(Ped), 0);
    check("midreset PedState", int'(PedState), 0);
    check("midreset ReqCount", int'(ReqCount), 0);
    check("midreset BtnClean", int'(BtnClean), 0);
    RST = 1'b0; PedBtn = 1'b0;
    wait_neg(3);

    // Bounce with 2-cycle periods is rejected.
    for (int i = 0; i < 8; i++) begin
      PedBtn = ((i / 2) % 2) == 0;
      wait_neg(1);
    end
    PedBtn = 1'b0;
    wait_neg(8);
    check("bounce BtnClean", int'(BtnClean), 0);
    check("bounce Ped", int'(Ped), 0);
    check("bounce ReqCount", int'(ReqCount), 0);

    // Press in IDLE while the road is already red: one-cycle Ped pulse.
    SigR = 1'b1; PedBtn = 1'b1;
    wait_neg(7);
    check("red press Ped", int'(Ped), 1);
    check("red press PedState", int'(PedState), 1);
    wait_neg(1);
    check("red press Ped after", int'(Ped), 0);
    check("red press PedState after", int'(PedState), 2);
    SigR = 1'b0; PedBtn = 1'b0;
    wait_neg(10);
    check("red press back idle", int'(PedState), 0);
    check("red press ReqCount", int'(ReqCount), 1);

    // 300 press/serve cycles: ReqCount saturates at 255.
    for (int i = 0; i < 300; i++) begin
      PedBtn = 1'b1;
      wait_neg(8);
      SigR = 1'b1; PedBtn = 1'b0;
      wait_neg(1);
      SigR = 1'b0;
      wait_neg(10);
      if (i == 253) check("sat reach ReqCount", int'(ReqCount), 255);
    end
    check("sat hold ReqCount", int'(ReqCount), 255);
    check("sat final PedState", int'(PedState), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
